// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller:
// state codes, supported opcodes and ALU operation selects.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_timer.sv
// Memory wait counter: clears on phase entry, counts stalled cycles,
// saturates, and flags the last wait cycle allowed before a timeout.
module ctrl_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TMR_WIDTH   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TMR_WIDTH-1:0] CNT_MAX = '1;
    // Flag one cycle early so a stall of MEM_TIMEOUT cycles traps on its last cycle.
    localparam logic [TMR_WIDTH-1:0] LIMIT =
        TMR_WIDTH'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [TMR_WIDTH-1:0] cnt_q;
    logic [TMR_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt_q >= LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Sequencing controller stepping the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, with bounded memory waits and sticky traps.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 7,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned TMR_WIDTH    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    imem_ready,
    input  logic                    dmem_ready,
    input  logic                    branch_taken,
    output logic                    imem_req,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_src,
    output logic                    branch,
    output logic                    memread,
    output logic                    memwrite,
    output logic                    memtoreg,
    output logic                    alusrc,
    output logic                    regwrite,
    output logic                    getpcplus4,
    output logic [1:0]              aluop,
    output logic                    instr_retired,
    output logic                    illegal,
    output logic                    bus_err,
    output logic [2:0]              state_o
);

    state_e                  state_q, state_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic                    illegal_q, illegal_d;
    logic                    bus_err_q, bus_err_d;
    logic                    tmr_clr, tmr_inc, tmr_expired;
    logic [6:0]              op7;

    assign op7 = 7'(op_q);

    ctrl_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMR_WIDTH  (TMR_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        tmr_inc       = 1'b0;
        tmr_clr       = 1'b0;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        branch        = 1'b0;
        memread       = 1'b0;
        memwrite      = 1'b0;
        memtoreg      = 1'b0;
        alusrc        = 1'b0;
        regwrite      = 1'b0;
        getpcplus4    = 1'b0;
        aluop         = ALUOP_ADD;
        instr_retired = 1'b0;

        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                if (op_supported(7'(opcode))) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                case (op7)
                    OP_R: begin
                        aluop   = ALUOP_R;
                        state_d = ST_WB;
                    end
                    OP_I: begin
                        aluop   = ALUOP_I;
                        alusrc  = 1'b1;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alusrc  = 1'b1;
                        state_d = ST_MEM;
                    end
                    OP_BRANCH: begin
                        branch        = 1'b1;
                        aluop         = ALUOP_BR;
                        pc_write      = 1'b1;
                        pc_src        = branch_taken;
                        instr_retired = 1'b1;
                        state_d       = ST_FETCH;
                    end
                    OP_JAL: begin
                        getpcplus4    = 1'b1;
                        regwrite      = 1'b1;
                        pc_write      = 1'b1;
                        pc_src        = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = ST_FETCH;
                    end
                    default: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                memread  = (op7 == OP_LOAD);
                memwrite = (op7 == OP_STORE);
                if (dmem_ready) begin
                    if (op7 == OP_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = ST_FETCH;
                    end
                end else if (tmr_expired) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_WB: begin
                regwrite      = 1'b1;
                memtoreg      = (op7 == OP_LOAD);
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase

        // Any phase change restarts the wait count for the next phase.
        tmr_clr = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state_o = state_q;

endmodule
